// File: rtl/avrg_ctrl_multi.sv
// Multi-channel averaging controller: scans CHANNELS sensor inputs on each prescaler tick,
// accumulates 2^LOG2_WIN scans per channel and emits one rounded average per channel.
module avrg_ctrl_multi #(
  parameter  int CHANNELS = 4,
  parameter  int DATA_W   = 12,
  parameter  int TICK_DIV = 50000000,
  parameter  int LOG2_WIN = 6,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_ovr,
  output logic              sample_req,
  output logic [CW-1:0]     sample_ch,
  input  logic              sample_ack,
  input  logic [DATA_W-1:0] sample_data,
  output logic              avrg_valid,
  output logic [CW-1:0]     avrg_ch,
  output logic [DATA_W-1:0] avrg_data,
  output logic              busy,
  output logic              overrun
);

  localparam int ACC_W = DATA_W + LOG2_WIN;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CW-1:0]    LAST_CH   = CW'(CHANNELS - 1);
  localparam logic [ACC_W:0]   HALF      = (ACC_W + 1)'(2 ** (LOG2_WIN - 1));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_LAST = 3'd5;
  localparam logic [2:0] S_AVRG = 3'd6;

  logic [2:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CW-1:0]       ch;
  logic [LOG2_WIN-1:0] scan;
  logic [ACC_W-1:0]    acc [CHANNELS];
  logic                tick;
  logic                lost_tick;
  logic [ACC_W:0]      round_sum;
  logic [DATA_W-1:0]   avrg_next;

  always_comb begin
    tick      = (state != S_IDLE) && (state != S_CLR) && (cnt == TICK_LAST);
    lost_tick = tick && ((state == S_REQ) || (state == S_GAP) ||
                         (state == S_LAST) || (state == S_AVRG));
  end

  // The extra top bit keeps the half-up rounding add from wrapping at full scale.
  assign round_sum = {1'b0, acc[ch]} + HALF;
  assign avrg_next = DATA_W'(round_sum >> LOG2_WIN);

  assign sample_req = (state == S_REQ);
  assign sample_ch  = ch;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if ((state == S_IDLE) || (state == S_CLR) || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (lost_tick) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      scan       <= '0;
      avrg_valid <= 1'b0;
      avrg_ch    <= '0;
      avrg_data  <= '0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      avrg_valid <= 1'b0;
      // Dropping en abandons the window outright; CLR on re-enable wipes any partial sums.
      if ((state != S_IDLE) && !en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (en) state <= S_CLR;
          S_CLR: begin
            ch    <= '0;
            scan  <= '0;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (tick) begin
              ch    <= '0;
              state <= S_REQ;
            end
          end
          S_REQ: begin
            if (sample_ack) begin
              acc[ch] <= acc[ch] + ACC_W'(sample_data);
              if (ch != LAST_CH) begin
                ch    <= ch + 1'b1;
                state <= S_GAP;
              end else begin
                state <= S_LAST;
              end
            end
          end
          S_GAP: state <= S_REQ;
          S_LAST: begin
            if (&scan) begin
              scan  <= '0;
              ch    <= '0;
              state <= S_AVRG;
            end else begin
              scan  <= scan + 1'b1;
              state <= S_WAIT;
            end
          end
          S_AVRG: begin
            avrg_valid <= 1'b1;
            avrg_ch    <= ch;
            avrg_data  <= avrg_next;
            acc[ch]    <= '0;
            if (ch == LAST_CH) begin
              state <= S_WAIT;
            end else begin
              ch <= ch + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
